// File: rtl/pi_cart_bridge_if.sv
// N64 PI cartridge bus as seen at the cartridge edge: multiplexed AD bus,
// address latch enables and active-low read/write strobes.
interface pi_cart_bridge_if;
  logic [15:0] ad_in;
  logic [15:0] ad_out;
  logic        ad_oe;
  logic        aleh;
  logic        alel;
  logic        read;
  logic        write;

  modport master (
    output ad_in, aleh, alel, read, write,
    input  ad_out, ad_oe
  );

  modport slave (
    input  ad_in, aleh, alel, read, write,
    output ad_out, ad_oe
  );
endinterface

// File: rtl/pi_cart_bridge.sv
// PI-bus cartridge slave: latches the multiplexed address, decodes it against
// programmable windows and drives flash/register accesses with burst increment.
module pi_cart_bridge #(
  parameter int                         FLASH_AW    = 19,
  parameter int                         BURST_W     = 8,
  parameter int                         SYNC_STAGES = 2,
  parameter int                         NUM_WIN     = 4,
  parameter logic [NUM_WIN*12-1:0]      WIN_TAG     = {12'h102, 12'h1EC, 12'h1E4, 12'h100},
  parameter logic [NUM_WIN*2-1:0]       WIN_KIND    = {2'd2, 2'd0, 2'd1, 2'd0},
  parameter logic [NUM_WIN-1:0]         WIN_BOOT    = 4'b1001,
  parameter logic [NUM_WIN*FLASH_AW-1:0] WIN_OFS    = '0,
  parameter logic [9:0]                 LOCK_REG    = 10'h300
) (
  input  logic                clk,
  input  logic                cold_reset,
  pi_cart_bridge_if.slave     pi,
  input  logic [15:0]         status_in,
  output logic [FLASH_AW-1:0] flash_addr,
  output logic                flash_ce_n,
  output logic                flash_oe_n,
  output logic                flash_we_n,
  output logic [9:0]          reg_addr,
  output logic [15:0]         reg_wr_data,
  output logic                reg_wr_stb,
  output logic                boot_done,
  output logic                proto_err
);

  localparam logic [1:0] KIND_FLASH = 2'd0;
  localparam logic [1:0] KIND_REG   = 2'd1;
  localparam logic [1:0] KIND_ZERO  = 2'd2;
  localparam logic [1:0] KIND_OFF   = 2'd3;

  // Bit order {alel, aleh, write, read}; strobes idle high, latch enables idle low.
  localparam logic [3:0] SYNC_INIT = 4'b0011;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_ARMED,
    S_RD,
    S_WR,
    S_RECOVER
  } state_t;

  genvar gi;

  logic [3:0] raw_in;
  logic [3:0] sync_now;

  assign raw_in = {pi.alel, pi.aleh, pi.write, pi.read};

  generate
    for (gi = 0; gi < 4; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] chain_reg;
      always_ff @(posedge clk or negedge cold_reset) begin
        if (!cold_reset) begin
          chain_reg <= {SYNC_STAGES{SYNC_INIT[gi]}};
        end else begin
          chain_reg <= {chain_reg[SYNC_STAGES-2:0], raw_in[gi]};
        end
      end
      assign sync_now[gi] = chain_reg[SYNC_STAGES-1];
    end
  endgenerate

  state_t              state_reg;
  logic [31:0]         addr_reg;
  logic [BURST_W-1:0]  burst_reg;
  logic [1:0]          kind_reg;
  logic [FLASH_AW-1:0] ofs_reg;
  logic [15:0]         wr_data_reg;
  logic                rd_last_reg;
  logic                wr_last_reg;
  logic                both_low_reg;

  // A strobe level is trusted only once two successive synchronised samples agree.
  logic rd_lo, rd_hi, wr_lo, wr_hi;
  logic ale_lo, ale_hi, ale_any;

  assign rd_lo   = !sync_now[0] && !rd_last_reg;
  assign rd_hi   =  sync_now[0] &&  rd_last_reg;
  assign wr_lo   = !sync_now[1] && !wr_last_reg;
  assign wr_hi   =  sync_now[1] &&  wr_last_reg;
  assign ale_lo  =  sync_now[3] && !sync_now[2];
  assign ale_hi  =  sync_now[3] &&  sync_now[2];
  assign ale_any =  sync_now[3] ||  sync_now[2];

  logic [NUM_WIN-1:0] win_match;

  generate
    for (gi = 0; gi < NUM_WIN; gi++) begin : g_win
      assign win_match[gi] = (WIN_TAG[gi*12 +: 12] == addr_reg[31:20])
                          && (WIN_KIND[gi*2 +: 2] != KIND_OFF)
                          && (!WIN_BOOT[gi] || !boot_done);
    end
  endgenerate

  logic                hit;
  logic [1:0]          hit_kind;
  logic [FLASH_AW-1:0] hit_ofs;

  // Walk from the top so the lowest-index match is the one left standing.
  always_comb begin
    hit      = 1'b0;
    hit_kind = KIND_OFF;
    hit_ofs  = '0;
    for (int i = NUM_WIN - 1; i >= 0; i--) begin
      if (win_match[i]) begin
        hit      = 1'b1;
        hit_kind = WIN_KIND[i*2 +: 2];
        hit_ofs  = WIN_OFS[i*FLASH_AW +: FLASH_AW];
      end
    end
  end

  logic [FLASH_AW-1:0] flash_calc;
  logic [15:0]         rd_reg_value;

  assign flash_calc   = ofs_reg + addr_reg[FLASH_AW:1] + FLASH_AW'(burst_reg);
  assign rd_reg_value = (addr_reg[10:1] == 10'd0) ? status_in : 16'hFFFF;
  assign reg_addr     = addr_reg[10:1];

  logic unused_addr_bits;
  assign unused_addr_bits = ^addr_reg;

  always_ff @(posedge clk or negedge cold_reset) begin
    if (!cold_reset) begin
      state_reg    <= S_IDLE;
      addr_reg     <= '0;
      burst_reg    <= '0;
      kind_reg     <= KIND_OFF;
      ofs_reg      <= '0;
      wr_data_reg  <= '0;
      rd_last_reg  <= 1'b1;
      wr_last_reg  <= 1'b1;
      both_low_reg <= 1'b0;
      flash_addr   <= '0;
      flash_ce_n   <= 1'b1;
      flash_oe_n   <= 1'b1;
      flash_we_n   <= 1'b1;
      pi.ad_out    <= '0;
      pi.ad_oe     <= 1'b0;
      reg_wr_data  <= '0;
      reg_wr_stb   <= 1'b0;
      boot_done    <= 1'b0;
      proto_err    <= 1'b0;
    end else begin
      rd_last_reg <= sync_now[0];
      wr_last_reg <= sync_now[1];
      reg_wr_stb  <= 1'b0;
      proto_err   <= 1'b0;

      if (ale_lo) begin
        addr_reg[15:0] <= pi.ad_in;
        burst_reg      <= '0;
      end
      if (ale_hi) begin
        addr_reg[31:16] <= pi.ad_in;
      end

      if (ale_any) begin
        // A new address phase aborts whatever access was in flight.
        state_reg    <= ale_hi ? S_DECODE : S_IDLE;
        flash_ce_n   <= 1'b1;
        flash_oe_n   <= 1'b1;
        flash_we_n   <= 1'b1;
        pi.ad_oe     <= 1'b0;
        both_low_reg <= 1'b0;
      end else begin
        case (state_reg)
          S_IDLE: begin
            state_reg <= S_IDLE;
          end
          S_DECODE: begin
            if (hit) begin
              kind_reg  <= hit_kind;
              ofs_reg   <= hit_ofs;
              state_reg <= S_ARMED;
            end else begin
              state_reg <= S_IDLE;
            end
          end
          S_ARMED: begin
            both_low_reg <= rd_lo && wr_lo;
            if (rd_lo && wr_lo) begin
              proto_err <= !both_low_reg;
            end else if (rd_lo) begin
              state_reg <= S_RD;
              case (kind_reg)
                KIND_FLASH: begin
                  flash_addr <= flash_calc;
                  flash_ce_n <= 1'b0;
                  flash_oe_n <= 1'b0;
                end
                KIND_REG: begin
                  pi.ad_oe  <= 1'b1;
                  pi.ad_out <= rd_reg_value;
                end
                KIND_ZERO: begin
                  pi.ad_oe  <= 1'b1;
                  pi.ad_out <= 16'h0000;
                end
                default: begin
                  pi.ad_oe <= 1'b0;
                end
              endcase
            end else if (wr_lo) begin
              wr_data_reg <= pi.ad_in;
              state_reg   <= S_WR;
              if (kind_reg == KIND_FLASH) begin
                flash_addr <= flash_calc;
                flash_ce_n <= 1'b0;
                flash_we_n <= 1'b0;
              end
            end
          end
          S_RD: begin
            if (rd_hi && wr_hi) begin
              flash_ce_n <= 1'b1;
              flash_oe_n <= 1'b1;
              pi.ad_oe   <= 1'b0;
              state_reg  <= S_RECOVER;
            end else if (kind_reg == KIND_REG) begin
              pi.ad_out <= rd_reg_value;
            end
          end
          S_WR: begin
            if (rd_hi && wr_hi) begin
              flash_ce_n <= 1'b1;
              flash_we_n <= 1'b1;
              state_reg  <= S_RECOVER;
              if (kind_reg == KIND_REG) begin
                reg_wr_stb  <= 1'b1;
                reg_wr_data <= wr_data_reg;
                if (addr_reg[10:1] == LOCK_REG && wr_data_reg[0]) begin
                  boot_done <= 1'b1;
                end
              end
            end
          end
          S_RECOVER: begin
            burst_reg <= burst_reg + 1'b1;
            state_reg <= S_ARMED;
          end
          default: begin
            state_reg <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pi_cart_bridge.sv
// Directed bench for pi_cart_bridge: a table of single accesses followed by
// hand-written burst, fault, boot-lock, wrap and reset sequences.
module tb_pi_cart_bridge;
  logic        clk;
  logic        cold_reset;
  logic [15:0] status_in;
  logic [18:0] flash_addr;
  logic        flash_ce_n, flash_oe_n, flash_we_n;
  logic [9:0]  reg_addr;
  logic [15:0] reg_wr_data;
  logic        reg_wr_stb, boot_done, proto_err;

  pi_cart_bridge_if pi ();

  pi_cart_bridge dut (
    .clk         (clk),
    .cold_reset  (cold_reset),
    .pi          (pi),
    .status_in   (status_in),
    .flash_addr  (flash_addr),
    .flash_ce_n  (flash_ce_n),
    .flash_oe_n  (flash_oe_n),
    .flash_we_n  (flash_we_n),
    .reg_addr    (reg_addr),
    .reg_wr_data (reg_wr_data),
    .reg_wr_stb  (reg_wr_stb),
    .boot_done   (boot_done),
    .proto_err   (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int stb_cnt = 0;
  int err_cnt = 0;

  always @(negedge clk) begin
    if (reg_wr_stb) stb_cnt++;
    if (proto_err) err_cnt++;
  end

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [15:0] data;
    logic [15:0] status;
    logic        ce_n;
    logic        oe_n;
    logic        we_n;
    logic [18:0] fa;
    logic        ad_oe;
    logic [15:0] ad_out;
    int          stb;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic latch_addr(input logic [31:0] a);
    pi.ad_in = a[15:0];
    pi.alel = 1'b1; pi.aleh = 1'b0;
    cyc(4);
    pi.alel = 1'b0;
    cyc(4);
    pi.ad_in = a[31:16];
    pi.alel = 1'b1; pi.aleh = 1'b1;
    cyc(4);
    pi.alel = 1'b0; pi.aleh = 1'b0;
    cyc(5);
  endtask

  task automatic strobe_on(input logic wr, input logic [15:0] d);
    pi.ad_in = d;
    if (wr) pi.write = 1'b0;
    else    pi.read  = 1'b0;
    cyc(6);
  endtask

  task automatic strobe_off();
    pi.read = 1'b1; pi.write = 1'b1;
    cyc(6);
  endtask

  // Raise ALEL mid-access: still active after two edges, dropped on the third.
  task automatic ale_abort(input string tag, input logic was_oe_n, input logic was_ad_oe);
    pi.alel = 1'b1;
    cyc(2);
    chk({tag, "_pre_oe_n"}, 32'(flash_oe_n), 32'(was_oe_n));
    chk({tag, "_pre_ad_oe"}, 32'(pi.ad_oe), 32'(was_ad_oe));
    cyc(1);
    chk({tag, "_ce_n"}, 32'(flash_ce_n), 32'h1);
    chk({tag, "_oe_n"}, 32'(flash_oe_n), 32'h1);
    chk({tag, "_we_n"}, 32'(flash_we_n), 32'h1);
    chk({tag, "_ad_oe"}, 32'(pi.ad_oe), 32'h0);
    pi.read = 1'b1; pi.write = 1'b1; pi.alel = 1'b0;
    cyc(6);
  endtask

  initial begin
    int s0, e0;
    vecs[0] = '{32'h10000010, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 19'h00008, 1'b0, 16'h0000, 0};
    vecs[1] = '{32'h1E400000, 1'b0, 16'h0000, 16'h1234, 1'b1, 1'b1, 1'b1, 19'h00000, 1'b1, 16'h1234, 0};
    vecs[2] = '{32'h1E400002, 1'b0, 16'h0000, 16'h5555, 1'b1, 1'b1, 1'b1, 19'h00000, 1'b1, 16'hFFFF, 0};
    vecs[3] = '{32'h10200000, 1'b0, 16'h0000, 16'h1234, 1'b1, 1'b1, 1'b1, 19'h00000, 1'b1, 16'h0000, 0};
    vecs[4] = '{32'h1EC00100, 1'b1, 16'hBEEF, 16'h0000, 1'b0, 1'b1, 1'b0, 19'h00080, 1'b0, 16'h0000, 0};
    vecs[5] = '{32'h1D000000, 1'b0, 16'h0000, 16'h1234, 1'b1, 1'b1, 1'b1, 19'h00000, 1'b0, 16'h0000, 0};
    vecs[6] = '{32'h1E400010, 1'b1, 16'hA5A5, 16'h0000, 1'b1, 1'b1, 1'b1, 19'h00000, 1'b0, 16'h0000, 1};
    vecs[7] = '{32'h10200000, 1'b1, 16'h1111, 16'h0000, 1'b1, 1'b1, 1'b1, 19'h00000, 1'b0, 16'h0000, 0};
    vecs[8] = '{32'h1EC7FFFE, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 19'h3FFFF, 1'b0, 16'h0000, 0};
    vecs[9] = '{32'h1E400600, 1'b1, 16'hFFFE, 16'h0000, 1'b1, 1'b1, 1'b1, 19'h00000, 1'b0, 16'h0000, 1};

    cold_reset = 1'b1;
    pi.read = 1'b1; pi.write = 1'b1; pi.alel = 1'b0; pi.aleh = 1'b0; pi.ad_in = 16'h0;
    status_in = 16'h0;
    #1 cold_reset = 1'b0;
    #2;
    chk("rst_ce_n", 32'(flash_ce_n), 32'h1);
    chk("rst_oe_n", 32'(flash_oe_n), 32'h1);
    chk("rst_we_n", 32'(flash_we_n), 32'h1);
    chk("rst_fa", 32'(flash_addr), 32'h0);
    chk("rst_ad_oe", 32'(pi.ad_oe), 32'h0);
    chk("rst_ad_out", 32'(pi.ad_out), 32'h0);
    chk("rst_reg_addr", 32'(reg_addr), 32'h0);
    chk("rst_reg_wr_data", 32'(reg_wr_data), 32'h0);
    chk("rst_stb", 32'(reg_wr_stb), 32'h0);
    chk("rst_boot_done", 32'(boot_done), 32'h0);
    chk("rst_proto_err", 32'(proto_err), 32'h0);
    cyc(3);
    cold_reset = 1'b1;
    cyc(4);

    for (int i = 0; i < 10; i++) begin
      status_in = vecs[i].status;
      latch_addr(vecs[i].addr);
      chk($sformatf("v%0d_reg_addr", i), 32'(reg_addr), 32'(vecs[i].addr[10:1]));
      s0 = stb_cnt;
      strobe_on(vecs[i].wr, vecs[i].data);
      chk($sformatf("v%0d_ce_n", i), 32'(flash_ce_n), 32'(vecs[i].ce_n));
      chk($sformatf("v%0d_oe_n", i), 32'(flash_oe_n), 32'(vecs[i].oe_n));
      chk($sformatf("v%0d_we_n", i), 32'(flash_we_n), 32'(vecs[i].we_n));
      chk($sformatf("v%0d_ad_oe", i), 32'(pi.ad_oe), 32'(vecs[i].ad_oe));
      if (!vecs[i].ce_n) chk($sformatf("v%0d_fa", i), 32'(flash_addr), 32'(vecs[i].fa));
      if (vecs[i].ad_oe) chk($sformatf("v%0d_ad_out", i), 32'(pi.ad_out), 32'(vecs[i].ad_out));
      strobe_off();
      chk($sformatf("v%0d_idle_ce_n", i), 32'(flash_ce_n), 32'h1);
      chk($sformatf("v%0d_idle_oe_n", i), 32'(flash_oe_n), 32'h1);
      chk($sformatf("v%0d_idle_we_n", i), 32'(flash_we_n), 32'h1);
      chk($sformatf("v%0d_idle_ad_oe", i), 32'(pi.ad_oe), 32'h0);
      chk($sformatf("v%0d_stb_count", i), 32'(stb_cnt - s0), 32'(vecs[i].stb));
      if (vecs[i].stb != 0) chk($sformatf("v%0d_reg_wr_data", i), 32'(reg_wr_data), 32'(vecs[i].data));
      chk($sformatf("v%0d_boot_done", i), 32'(boot_done), 32'h0);
      $display("vector %0d addr=%h wr=%0d done", i, vecs[i].addr, vecs[i].wr);
    end

    latch_addr(32'h10000010);
    for (int i = 0; i < 3; i++) begin
      strobe_on(1'b0, 16'h0);
      chk("burst_fa", 32'(flash_addr), 32'h8 + 32'(i));
      chk("burst_oe_n", 32'(flash_oe_n), 32'h0);
      chk("burst_ce_n", 32'(flash_ce_n), 32'h0);
      chk("burst_ad_oe", 32'(pi.ad_oe), 32'h0);
      strobe_off();
      chk("burst_idle_oe_n", 32'(flash_oe_n), 32'h1);
      chk("burst_idle_ce_n", 32'(flash_ce_n), 32'h1);
      $display("burst read %0d fa=%h", i, flash_addr);
    end

    latch_addr(32'h10000000);
    e0 = err_cnt;
    pi.read = 1'b0; pi.write = 1'b0;
    cyc(6);
    chk("fault_ce_n", 32'(flash_ce_n), 32'h1);
    chk("fault_oe_n", 32'(flash_oe_n), 32'h1);
    chk("fault_we_n", 32'(flash_we_n), 32'h1);
    strobe_off();
    chk("fault_pulses", 32'(err_cnt - e0), 32'h1);
    $display("protocol fault: proto_err pulses=%0d", err_cnt - e0);
    strobe_on(1'b0, 16'h0);
    chk("fault_then_read_oe_n", 32'(flash_oe_n), 32'h0);
    chk("fault_then_read_fa", 32'(flash_addr), 32'h0);
    ale_abort("ale_flash", 1'b0, 1'b0);
    $display("ale abort during flash read");
    status_in = 16'h4321;
    latch_addr(32'h1E400000);
    strobe_on(1'b0, 16'h0);
    chk("ale_reg_ad_out", 32'(pi.ad_out), 32'h4321);
    ale_abort("ale_reg", 1'b1, 1'b1);
    $display("ale abort during register read");

    latch_addr(32'h1EC001FE);
    for (int i = 0; i < 257; i++) begin
      strobe_on(1'b1, 16'(i));
      chk("wrap_fa", 32'(flash_addr), 32'h0FF + 32'(i % 256));
      chk("wrap_we_n", 32'(flash_we_n), 32'h0);
      chk("wrap_oe_n", 32'(flash_oe_n), 32'h1);
      strobe_off();
      chk("wrap_idle_we_n", 32'(flash_we_n), 32'h1);
      $display("flash write %0d fa=%h", i, flash_addr);
    end

    latch_addr(32'h1E400600);
    s0 = stb_cnt;
    strobe_on(1'b1, 16'h0001);
    strobe_off();
    chk("lock_stb_count", 32'(stb_cnt - s0), 32'h1);
    chk("lock_reg_addr", 32'(reg_addr), 32'h300);
    chk("lock_reg_wr_data", 32'(reg_wr_data), 32'h0001);
    chk("lock_boot_done", 32'(boot_done), 32'h1);
    $display("boot lock write: boot_done=%0d", boot_done);
    latch_addr(32'h10000000);
    strobe_on(1'b0, 16'h0);
    chk("locked_ce_n", 32'(flash_ce_n), 32'h1);
    chk("locked_oe_n", 32'(flash_oe_n), 32'h1);
    chk("locked_ad_oe", 32'(pi.ad_oe), 32'h0);
    strobe_off();
    $display("boot window access after lock");

    latch_addr(32'h1EC00000);
    strobe_on(1'b0, 16'h0);
    chk("prerst_oe_n", 32'(flash_oe_n), 32'h0);
    #2 cold_reset = 1'b0;
    #1;
    chk("midrst_ce_n", 32'(flash_ce_n), 32'h1);
    chk("midrst_oe_n", 32'(flash_oe_n), 32'h1);
    chk("midrst_ad_oe", 32'(pi.ad_oe), 32'h0);
    chk("midrst_boot_done", 32'(boot_done), 32'h0);
    chk("midrst_fa", 32'(flash_addr), 32'h0);
    $display("reset mid-access");
    pi.read = 1'b1;
    cyc(2);
    cold_reset = 1'b1;
    cyc(4);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
